// File: rtl/alu_issue_stage_if.sv
// Issue-stage bundle: upstream decoded-instruction handshake plus the
// ALU operand/control bus driven by the issue register.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    // upstream side
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic            flush;

    // ALU side
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_control;
    logic [XLEN-1:0] out_operand_a;
    logic [XLEN-1:0] out_operand_b;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    // issue stage: initiator of the ALU bus, sink of the upstream stream
    modport master (
        input  in_valid,
        input  in_instr,
        input  in_pc,
        input  in_rs1_data,
        input  in_rs2_data,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_alu_control,
        output out_operand_a,
        output out_operand_b,
        output out_rs2_data,
        output out_pc,
        output out_illegal
    );

    // surroundings: decode stage feeding in, ALU consuming out
    modport slave (
        output in_valid,
        output in_instr,
        output in_pc,
        output in_rs1_data,
        output in_rs2_data,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_alu_control,
        input  out_operand_a,
        input  out_operand_b,
        input  out_rs2_data,
        input  out_pc,
        input  out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I execute-side issue register: decodes one instruction per handshake
// into an ALU code and operand pair and holds it under valid/ready control.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_issue_stage_if.master  bus
);

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_JALR = 4'b1010;

    // major opcodes (bits [1:0]=11 are part of the compare)
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // operand_a sources
    localparam logic [1:0] A_ZERO = 2'd0;
    localparam logic [1:0] A_RS1  = 2'd1;
    localparam logic [1:0] A_PC   = 2'd2;

    // operand_b sources
    localparam logic [2:0] B_ZERO  = 3'd0;
    localparam logic [2:0] B_RS2   = 3'd1;
    localparam logic [2:0] B_IMM_I = 3'd2;
    localparam logic [2:0] B_IMM_S = 3'd3;
    localparam logic [2:0] B_IMM_U = 3'd4;
    localparam logic [2:0] B_IMM_J = 3'd5;
    localparam logic [2:0] B_SHAMT = 3'd6;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] shamt;

    logic [3:0]      dec_code;
    logic [1:0]      dec_sel_a;
    logic [2:0]      dec_sel_b;
    logic            dec_illegal;

    logic [3:0]      nxt_code;
    logic [XLEN-1:0] nxt_operand_a;
    logic [XLEN-1:0] nxt_operand_b;

    logic            load;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Branch targets are formed in the fetch/branch unit, so no B-immediate
    // is built here; the ALU only sees the compare operands.
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Immediate shifts hand the ALU the bare shift amount rather than the
    // whole I-field, so instr[30] (the SRA selector) never leaks into b.
    assign shamt = {27'b0, instr[24:20]};

    // funct3 -> operation shared by OP and OP-IMM (no SUB/SRA distinction)
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Opcode decode: operation code, operand sources and legality
    always_comb begin
        dec_code    = ALU_ADD;
        dec_sel_a   = A_ZERO;
        dec_sel_b   = B_ZERO;
        dec_illegal = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec_sel_a = A_RS1;
                dec_sel_b = B_RS2;
                if (funct7 == F7_BASE) begin
                    dec_code = base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_code = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_code = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                dec_sel_a = A_RS1;
                dec_sel_b = B_IMM_I;
                dec_code  = base_op(funct3);
                if (funct3 == 3'b001) begin
                    dec_sel_b = B_SHAMT;
                    if (funct7 != F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end else if (funct3 == 3'b101) begin
                    dec_sel_b = B_SHAMT;
                    if (instr[30]) begin
                        dec_code = ALU_SRA;
                    end
                    if (instr[31] || (instr[29:25] != 5'b0)) begin
                        dec_illegal = 1'b1;
                    end
                end
            end

            OPC_LOAD: begin
                dec_sel_a = A_RS1;
                dec_sel_b = B_IMM_I;
            end

            OPC_STORE: begin
                dec_sel_a = A_RS1;
                dec_sel_b = B_IMM_S;
            end

            OPC_BRANCH: begin
                dec_sel_a = A_RS1;
                dec_sel_b = B_RS2;
                case (funct3)
                    3'b000, 3'b001: dec_code = ALU_SUB;
                    3'b100, 3'b101: dec_code = ALU_SLT;
                    3'b110, 3'b111: dec_code = ALU_SLTU;
                    default:        dec_illegal = 1'b1;
                endcase
            end

            OPC_LUI: begin
                dec_sel_a = A_ZERO;
                dec_sel_b = B_IMM_U;
            end

            OPC_AUIPC: begin
                dec_sel_a = A_PC;
                dec_sel_b = B_IMM_U;
            end

            OPC_JAL: begin
                dec_sel_a = A_PC;
                dec_sel_b = B_IMM_J;
            end

            OPC_JALR: begin
                dec_code  = ALU_JALR;
                dec_sel_a = A_RS1;
                dec_sel_b = B_IMM_I;
                if (funct3 != 3'b000) begin
                    dec_illegal = 1'b1;
                end
            end

            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Operand muxes; an illegal instruction issues as ADD 0,0
    always_comb begin
        nxt_code      = dec_code;
        nxt_operand_a = '0;
        nxt_operand_b = '0;

        case (dec_sel_a)
            A_RS1:   nxt_operand_a = bus.in_rs1_data;
            A_PC:    nxt_operand_a = bus.in_pc;
            default: nxt_operand_a = '0;
        endcase

        case (dec_sel_b)
            B_RS2:   nxt_operand_b = bus.in_rs2_data;
            B_IMM_I: nxt_operand_b = imm_i;
            B_IMM_S: nxt_operand_b = imm_s;
            B_IMM_U: nxt_operand_b = imm_u;
            B_IMM_J: nxt_operand_b = imm_j;
            B_SHAMT: nxt_operand_b = shamt;
            default: nxt_operand_b = '0;
        endcase

        if (dec_illegal) begin
            nxt_code      = ALU_ADD;
            nxt_operand_a = '0;
            nxt_operand_b = '0;
        end
    end

    // Register frees up in the same cycle the consumer takes it: no bubble.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;

    // Issue register: flush beats load, load beats drain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid       <= 1'b0;
            bus.out_alu_control <= '0;
            bus.out_operand_a   <= '0;
            bus.out_operand_b   <= '0;
            bus.out_rs2_data    <= '0;
            bus.out_pc          <= '0;
            bus.out_illegal     <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (load) begin
            bus.out_valid       <= 1'b1;
            bus.out_alu_control <= nxt_code;
            bus.out_operand_a   <= nxt_operand_a;
            bus.out_operand_b   <= nxt_operand_b;
            bus.out_rs2_data    <= bus.in_rs2_data;
            bus.out_pc          <= bus.in_pc;
            bus.out_illegal     <= dec_illegal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: mask/match instruction-table reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_alu_issue_stage;

    logic clk;
    logic reset_n;

    alu_issue_stage_if bus();

    alu_issue_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  code;
        int          asel;   // 0 zero, 1 rs1, 2 pc
        int          bsel;   // 0 zero, 1 rs2, 2 imm_i, 3 imm_s, 4 imm_u, 5 imm_j, 6 shamt
    } rule_t;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } dec_t;

    rule_t rules[$];

    task automatic add_rule(input logic [31:0] m, input logic [31:0] v,
                            input logic [3:0] c, input int as, input int bs);
        rule_t r;
        r.mask = m; r.match = v; r.code = c; r.asel = as; r.bsel = bs;
        rules.push_back(r);
    endtask

    task automatic build_rules();
        // register-register
        add_rule(32'hFE00707F, 32'h00000033, 4'h0, 1, 1);
        add_rule(32'hFE00707F, 32'h40000033, 4'h1, 1, 1);
        add_rule(32'hFE00707F, 32'h00001033, 4'h7, 1, 1);
        add_rule(32'hFE00707F, 32'h00002033, 4'h5, 1, 1);
        add_rule(32'hFE00707F, 32'h00003033, 4'h6, 1, 1);
        add_rule(32'hFE00707F, 32'h00004033, 4'h4, 1, 1);
        add_rule(32'hFE00707F, 32'h00005033, 4'h8, 1, 1);
        add_rule(32'hFE00707F, 32'h40005033, 4'h9, 1, 1);
        add_rule(32'hFE00707F, 32'h00006033, 4'h3, 1, 1);
        add_rule(32'hFE00707F, 32'h00007033, 4'h2, 1, 1);
        // register-immediate
        add_rule(32'h0000707F, 32'h00000013, 4'h0, 1, 2);
        add_rule(32'h0000707F, 32'h00002013, 4'h5, 1, 2);
        add_rule(32'h0000707F, 32'h00003013, 4'h6, 1, 2);
        add_rule(32'h0000707F, 32'h00004013, 4'h4, 1, 2);
        add_rule(32'h0000707F, 32'h00006013, 4'h3, 1, 2);
        add_rule(32'h0000707F, 32'h00007013, 4'h2, 1, 2);
        add_rule(32'hFE00707F, 32'h00001013, 4'h7, 1, 6);
        add_rule(32'hFE00707F, 32'h00005013, 4'h8, 1, 6);
        add_rule(32'hFE00707F, 32'h40005013, 4'h9, 1, 6);
        // memory
        add_rule(32'h0000007F, 32'h00000003, 4'h0, 1, 2);
        add_rule(32'h0000007F, 32'h00000023, 4'h0, 1, 3);
        // branches
        add_rule(32'h0000707F, 32'h00000063, 4'h1, 1, 1);
        add_rule(32'h0000707F, 32'h00001063, 4'h1, 1, 1);
        add_rule(32'h0000707F, 32'h00004063, 4'h5, 1, 1);
        add_rule(32'h0000707F, 32'h00005063, 4'h5, 1, 1);
        add_rule(32'h0000707F, 32'h00006063, 4'h6, 1, 1);
        add_rule(32'h0000707F, 32'h00007063, 4'h6, 1, 1);
        // upper / jumps
        add_rule(32'h0000007F, 32'h00000037, 4'h0, 0, 4);
        add_rule(32'h0000007F, 32'h00000017, 4'h0, 2, 4);
        add_rule(32'h0000007F, 32'h0000006F, 4'h0, 2, 5);
        add_rule(32'h0000707F, 32'h00000067, 4'hA, 1, 2);
    endtask

    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
        dec_t d;
        logic signed [31:0] s;
        logic [31:0] sign, imm_i, imm_s, imm_u, imm_j, shamt, opa, opb;
        s     = ins;
        sign  = $unsigned(s >>> 31);
        imm_i = $unsigned(s >>> 20);
        imm_s = (imm_i & ~32'h1F) | ((ins >> 7) & 32'h1F);
        imm_u = ins & 32'hFFFFF000;
        imm_j = (sign & 32'hFFF00000) | (ins & 32'h000FF000) |
                ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
        shamt = (ins >> 20) & 32'h1F;
        d.code = 4'h0; d.a = 32'h0; d.b = 32'h0; d.ill = 1'b1;
        foreach (rules[k]) begin
            if ((ins & rules[k].mask) == rules[k].match) begin
                case (rules[k].asel)
                    1:       opa = rs1;
                    2:       opa = pc;
                    default: opa = 32'h0;
                endcase
                case (rules[k].bsel)
                    1:       opb = rs2;
                    2:       opb = imm_i;
                    3:       opb = imm_s;
                    4:       opb = imm_u;
                    5:       opb = imm_j;
                    6:       opb = shamt;
                    default: opb = 32'h0;
                endcase
                d.ill = 1'b0; d.code = rules[k].code; d.a = opa; d.b = opb;
            end
        end
        return d;
    endfunction

    // expected issue register
    logic        m_valid;
    dec_t        m_dec;
    logic [31:0] m_pc;
    logic [31:0] m_rs2;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
        end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
            m_valid <= 1'b1;
            m_dec   <= ref_decode(bus.in_instr, bus.in_pc, bus.in_rs1_data, bus.in_rs2_data);
            m_pc    <= bus.in_pc;
            m_rs2   <= bus.in_rs2_data;
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_n) begin
            check("m_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
            check("m_in_ready", {31'b0, bus.in_ready}, {31'b0, (!m_valid || bus.out_ready)});
            if (m_valid) begin
                check("m_code",    {28'b0, bus.out_alu_control}, {28'b0, m_dec.code});
                check("m_a",       bus.out_operand_a, m_dec.a);
                check("m_b",       bus.out_operand_b, m_dec.b);
                check("m_illegal", {31'b0, bus.out_illegal}, {31'b0, m_dec.ill});
                check("m_pc",      bus.out_pc, m_pc);
                check("m_rs2",     bus.out_rs2_data, m_rs2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic rdy, input logic fl);
        bus.in_valid    = v;
        bus.in_instr    = ins;
        bus.in_pc       = pc;
        bus.in_rs1_data = r1;
        bus.in_rs2_data = r2;
        bus.out_ready   = rdy;
        bus.flush       = fl;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   {31'b0, bus.out_valid}, 32'h0);
        check({tag, "_code"},    {28'b0, bus.out_alu_control}, 32'h0);
        check({tag, "_a"},       bus.out_operand_a, 32'h0);
        check({tag, "_b"},       bus.out_operand_b, 32'h0);
        check({tag, "_rs2"},     bus.out_rs2_data, 32'h0);
        check({tag, "_pc"},      bus.out_pc, 32'h0);
        check({tag, "_illegal"}, {31'b0, bus.out_illegal}, 32'h0);
        check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'h1);
    endtask

    logic [31:0] extra [12];

    initial begin
        dec_t d;
        reset_n = 1'b0;
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        build_rules();

        // pin the model with hand-derived decodes
        d = ref_decode(32'h4030D093, 32'h0, 32'h0, 32'h0);
        check("pin_srai_code", {28'b0, d.code}, 32'h9);
        check("pin_srai_b", d.b, 32'h3);
        d = ref_decode(32'hFFC08067, 32'h0, 32'h1000, 32'h0);
        check("pin_jalr_b", d.b, 32'hFFFFFFFC);
        d = ref_decode(32'h0230D093, 32'h0, 32'h5, 32'h0);
        check("pin_bad_ill", {31'b0, d.ill}, 32'h1);
        d = ref_decode(32'h0020A423, 32'h0, 32'h0, 32'h0);
        check("pin_sw_b", d.b, 32'h8);
        d = ref_decode(32'h001000EF, 32'h40, 32'h0, 32'h0);
        check("pin_jal_b", d.b, 32'h800);

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check_all_zero("rst");

        // add / sub
        drive(1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1, 0); tick();
        check("add_valid", {31'b0, bus.out_valid}, 32'h1);
        check("add_code", {28'b0, bus.out_alu_control}, 32'h0);
        check("add_a", bus.out_operand_a, 32'd5);
        check("add_b", bus.out_operand_b, 32'd7);
        check("add_pc", bus.out_pc, 32'h100);
        drive(1, 32'h402081B3, 32'h104, 32'd5, 32'd7, 1, 0); tick();
        check("sub_code", {28'b0, bus.out_alu_control}, 32'h1);

        // srai and malformed srai
        drive(1, 32'h4030D093, 32'h108, 32'hF0, 32'h0, 1, 0); tick();
        check("srai_code", {28'b0, bus.out_alu_control}, 32'h9);
        check("srai_b", bus.out_operand_b, 32'h3);
        drive(1, 32'h0230D093, 32'h10C, 32'hF0, 32'h0, 1, 0); tick();
        check("bad_valid", {31'b0, bus.out_valid}, 32'h1);
        check("bad_ill", {31'b0, bus.out_illegal}, 32'h1);
        check("bad_code", {28'b0, bus.out_alu_control}, 32'h0);
        check("bad_a", bus.out_operand_a, 32'h0);

        // branch / lui / jalr / jal
        drive(1, 32'h0020E463, 32'h110, 32'h11, 32'h22, 1, 0); tick();
        check("bltu_code", {28'b0, bus.out_alu_control}, 32'h6);
        check("bltu_a", bus.out_operand_a, 32'h11);
        check("bltu_b", bus.out_operand_b, 32'h22);
        drive(1, 32'h123450B7, 32'h114, 32'h55, 32'h66, 1, 0); tick();
        check("lui_a", bus.out_operand_a, 32'h0);
        check("lui_b", bus.out_operand_b, 32'h12345000);
        drive(1, 32'hFFC08067, 32'h118, 32'h2000, 32'h0, 1, 0); tick();
        check("jalr_code", {28'b0, bus.out_alu_control}, 32'hA);
        check("jalr_b", bus.out_operand_b, 32'hFFFFFFFC);
        drive(1, 32'h001000EF, 32'h11C, 32'h0, 32'h0, 1, 0); tick();
        check("jal_a", bus.out_operand_a, 32'h11C);
        check("jal_b", bus.out_operand_b, 32'h800);

        // mixed instruction table with intermittent back-pressure (model-checked)
        extra[0]  = 32'hFFF08093;  // addi -1
        extra[1]  = 32'hFFC12083;  // lw -4
        extra[2]  = 32'h0020A423;  // sw 8
        extra[3]  = 32'h00001017;  // auipc
        extra[4]  = 32'h00000000;  // low bits 00
        extra[5]  = 32'h0020A063;  // branch funct3 010
        extra[6]  = 32'h4020D0B3;  // sra
        extra[7]  = 32'h0020F0B3;  // and
        extra[8]  = 32'h00209093;  // slli 2
        extra[9]  = 32'h0220C0B3;  // R-type funct7 0000001
        extra[10] = 32'h00000073;  // system opcode
        extra[11] = 32'hFE208EE3;  // beq negative offset
        for (int i = 0; i < 12; i++) begin
            drive(1, extra[i], 32'h500 + 32'(i * 4), 32'(i * 3 + 1), 32'(i * 7 + 2),
                  (i % 3) != 1, 0);
            tick();
        end
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0); tick();
        check("drain_valid", {31'b0, bus.out_valid}, 32'h0);

        // back-pressure: first held, second loads with no bubble
        drive(1, 32'h002081B3, 32'h200, 32'd1, 32'd2, 0, 0); tick();
        check("bp_first_valid", {31'b0, bus.out_valid}, 32'h1);
        check("bp_in_ready0", {31'b0, bus.in_ready}, 32'h0);
        drive(1, 32'h402081B3, 32'h204, 32'd9, 32'd4, 0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_pc", bus.out_pc, 32'h200);
            check("bp_hold_a", bus.out_operand_a, 32'd1);
            check("bp_hold_in_ready", {31'b0, bus.in_ready}, 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready1", {31'b0, bus.in_ready}, 32'h1);
        tick();
        check("bp_second_pc", bus.out_pc, 32'h204);
        check("bp_second_code", {28'b0, bus.out_alu_control}, 32'h1);
        check("bp_second_valid", {31'b0, bus.out_valid}, 32'h1);
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0); tick();

        // flush with an incoming instruction while holding
        drive(1, 32'h002081B3, 32'h300, 32'd3, 32'd3, 0, 0); tick();
        check("fl_hold_valid", {31'b0, bus.out_valid}, 32'h1);
        drive(1, 32'h402081B3, 32'h304, 32'd8, 32'd1, 0, 1); tick();
        check("fl_valid", {31'b0, bus.out_valid}, 32'h0);
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0); tick();
        check("fl_dropped", {31'b0, bus.out_valid}, 32'h0);

        // async reset while holding
        drive(1, 32'h123450B7, 32'h400, 32'd3, 32'd4, 0, 0); tick();
        check("rh_valid", {31'b0, bus.out_valid}, 32'h1);
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rh");
        tick();
        reset_n = 1'b1;
        tick();
        check("rh_post_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rh_post_in_ready", {31'b0, bus.in_ready}, 32'h1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
